// File: rtl/branch_seq.sv
// Fetch-PC sequencer with a 2-bit saturating-counter branch-direction predictor.
// Redirects fetch and flushes younger work when the execute stage resolves a mispredict.
module branch_seq #(
  parameter int unsigned    PC_W   = 8,
  parameter int unsigned    INC    = 2,
  parameter int unsigned    IDX_W  = 4,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_f,
  input  logic [PC_W-1:0] tgt_f,
  input  logic            ex_br,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_tgt,
  input  logic            ex_pred,
  input  logic            bSel,
  output logic [PC_W-1:0] pc_f,
  output logic            pred_f,
  output logic            flush,
  output logic [7:0]      mis_cnt
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CNT_W = 8;
  localparam logic [1:0]  CTR_WN  = 2'b01;
  localparam logic [1:0]  CTR_MAX = 2'b11;
  localparam logic [1:0]  CTR_MIN = 2'b00;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [1:0]       ctr [DEPTH];
  logic [1:0]       ctr_upd;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] train_idx;
  logic [PC_W-1:0]  seq_pc;
  logic [PC_W-1:0]  fix_pc;
  logic             mis;
  logic [CNT_W-1:0] mis_cnt_q;

  assign fetch_idx = pc_q[IDX_W:1];
  assign train_idx = ex_pc[IDX_W:1];

  // Lookup reads the registered table, so a same-cycle training write is seen next cycle.
  assign pred_f = br_f & ctr[fetch_idx][1];
  assign mis    = ex_br & (bSel != ex_pred);
  assign flush  = mis;

  assign seq_pc = pc_q  + PC_W'(INC);
  assign fix_pc = bSel ? ex_tgt : (ex_pc + PC_W'(INC));

  // Next-PC select: redirect beats stall beats predicted-taken beats sequential.
  always_comb begin
    pc_d = seq_pc;
    if (mis) begin
      pc_d = fix_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_f) begin
      pc_d = tgt_f;
    end
  end

  // Saturating update of the counter being trained.
  always_comb begin
    ctr_upd = ctr[train_idx];
    if (bSel) begin
      if (ctr[train_idx] != CTR_MAX) ctr_upd = ctr[train_idx] + 2'd1;
    end else begin
      if (ctr[train_idx] != CTR_MIN) ctr_upd = ctr[train_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RST_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ctr[i] <= CTR_WN;
      end
    end else if (ex_br) begin
      ctr[train_idx] <= ctr_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_cnt_q <= '0;
    end else if (mis && (mis_cnt_q != CNT_MAX)) begin
      mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  assign pc_f    = pc_q;
  assign mis_cnt = mis_cnt_q;

endmodule
